// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters: rotating-priority selection, registered
// grant held until done, request drop, or hold timeout.
module rr_arbiter_8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int unsigned CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n, id_n, pick;
  logic [CW-1:0]  cnt, cnt_n;
  logic [N-1:0]   gnt_n, masked;
  logic           valid_n, timeout_n;
  logic           hold_exp, release_now;

  function automatic logic [IDW-1:0] lowest(input logic [N-1:0] v);
    lowest = '0;
    for (int unsigned i = N; i > 0; i--)
      if (v[i-1]) lowest = IDW'(i - 1);
  endfunction

  // Requests at or above ptr take precedence; fall back to the full vector to wrap.
  assign masked = req & ({N{1'b1}} << ptr);
  assign pick   = (masked != '0) ? lowest(masked) : lowest(req);

  assign hold_exp    = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  assign release_now = done || !req[gnt_id] || hold_exp;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = gnt;
    id_n      = gnt_id;
    valid_n   = gnt_valid;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          state_n = GRANT;
          gnt_n   = N'(1) << pick;
          id_n    = pick;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (cnt != '1) cnt_n = cnt + 1'b1;
        if (release_now) begin
          state_n   = IDLE;
          gnt_n     = '0;
          id_n      = '0;
          valid_n   = 1'b0;
          ptr_n     = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_n = !done && req[gnt_id];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_id    <= id_n;
      gnt_valid <= valid_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: vector table plus multi-cycle sequences
// (fairness sweep, hold timeout, asynchronous reset).
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_8 #(.N(8), .IDW(3), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] ei,
                     input logic ev, input logic et);
    checks++;
    if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev || timeout !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
               name, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // req, done -> gnt, id, valid, timeout after the next edge
    tbl[0]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[6]  = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{8'h84, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[8]  = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[10] = '{8'h84, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[12] = '{8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[14] = '{8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[15] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[16] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[17] = '{8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[18] = '{8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[19] = '{8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[20] = '{8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};

    rst = 1'b1; req = '0; done = 1'b0;
    #2;
    chk("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].valid, tbl[i].to);
    end

    // Fairness: all requesting, done on the 2nd cycle of each grant.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
      e = 3'(k % 8);
      step(8'hFF, 1'b0);
      chk($sformatf("rr_grant%0d", k), 8'h01 << e, e, 1'b1, 1'b0);
      step(8'hFF, 1'b0);
      chk($sformatf("rr_hold%0d", k), 8'h01 << e, e, 1'b1, 1'b0);
      step(8'hFF, 1'b1);
      chk($sformatf("rr_gap%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Hold timeout: owner 4 never completes.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(8'h10, 1'b0);
      chk($sformatf("hold_c%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    step(8'h10, 1'b0);
    chk("timeout_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    step(8'h10, 1'b0);
    chk("regrant_after_timeout", 8'h10, 3'd4, 1'b1, 1'b0);
    for (int c = 1; c < 16; c++) step(8'h10, 1'b0);
    chk("hold_last_cycle", 8'h10, 3'd4, 1'b1, 1'b0);
    step(8'h10, 1'b1);
    chk("done_at_limit_no_timeout", 8'h00, 3'd0, 1'b0, 1'b0);

    // Async reset mid-grant; ptr is 5 here, so a reset ptr is visible as a grant to 0.
    step(8'h40, 1'b0);
    chk("pre_reset_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_clear", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h41;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Candidate selection uses a rotating-priority encoder over the request vector.
- Grants are registered and held until the owner signals completion, drops its request, or hits a hold timeout.
- Sits in front of any shared datapath that today is fed by a fixed 8:3 priority encode, and removes starvation of low-index sources.

Parameters:
- N, 8, number of requesters (block is verified at 8 only).
- IDW, 3, width of grant index (log2 N).
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- done  input  1  completion pulse from the current owner; meaningful only while gnt_valid=1.
- gnt  output  N  one-hot grant vector; all-zero when idle.
- gnt_id  output  IDW  binary index of current owner; 0 when idle.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, rst=1):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - Round-robin pointer ptr=0, hold counter=0, state=IDLE.
  - Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Else select the winner by rotating priority: search indices ptr, ptr+1, ..., wrapping mod N.
  - First set bit wins.
  - Implementation is the masked/unmasked encode: masked = req & (~0 << ptr); if masked != 0, pick the lowest set index of masked; else pick the lowest set index of req.
  - Next edge: gnt_valid=1, gnt=one-hot(winner), gnt_id=winner, counter=0, state=GRANT.
  - Request-to-grant latency: 1 cycle.
- GRANT:
  - The counter increments every cycle, saturating.
  - Release conditions, evaluated every cycle, in priority order:
    1. done=1.
    2. req[gnt_id]=0.
    3. MAX_HOLD!=0 and counter==MAX_HOLD-1.
  - On release, at the next edge: gnt=0, gnt_valid=0, gnt_id=0, ptr=(old gnt_id+1) mod N, state=IDLE.
  - timeout pulses high for exactly that one cycle, and only when condition 3 alone caused the release.
  - done coincident with the timeout cycle is a normal release and gives no timeout pulse.
- Gap between grants: always at least one IDLE cycle with gnt_valid=0. Back-to-back grants are not supported.
- Requests from non-owners during GRANT are ignored. They are arbitrated in the following IDLE cycle using the updated ptr.
- done while gnt_valid=0 is ignored.
- Wrap-around: owner 7 releases -> ptr=0.
- Fairness: a continuously asserted request is granted within N grants.
- Invariants: gnt is always one-hot or zero, and gnt==(gnt_valid ? 1<<gnt_id : 0).

Test Plan:
- Reset then req=8'b0000_0000 for 5 cycles -> gnt_valid stays 0, gnt=0, gnt_id=0, timeout=0.
- From reset (ptr=0), req=8'b1000_0100 -> 1 cycle later gnt=8'b0000_0100, gnt_id=2. Pulse done -> next cycle gnt=0 (IDLE). Following cycle gnt=8'b1000_0000, gnt_id=7 (ptr=3). Pulse done -> ptr wraps to 0, and requester 2 is granted next.
- req=8'hFF held, done pulsed on the 2nd cycle of each grant -> grant order 0,1,2,...,7,0, each grant separated by exactly one idle cycle; no index repeats before all 8 are served.
- MAX_HOLD=16, req=8'b0001_0000 held, done never asserted -> gnt_id=4 for exactly 16 cycles. timeout=1 for one cycle coincident with gnt_valid falling to 0. Requester 4 is re-granted after one IDLE cycle.
- Owner 3 drops req[3] mid-grant while req[5]=1 -> next edge gnt=0, timeout=0; one cycle later gnt_id=5.
- rst asserted asynchronously (between clock edges) while gnt_id=6 -> all outputs 0 immediately. After release, with req=8'b0100_0001, the first grant goes to index 0, confirming ptr was reset.
